// File: rtl/riscv_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam logic [63:0] DEF_RESET_PC  = 64'h0;
    localparam int          DEF_MEM_BYTES = 132;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// PC register with next-PC select: reset, redirect (word-aligned), +4, hold.
// Latency: new PC visible the cycle after the select; no backpressure of its own.
module program_counter
    import riscv_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] target,
    input  logic        advance,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4
);

    assign pc_plus4 = pc + 64'd4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {target[63:2], 2'b00};
        end else if (advance) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads one word per cycle into a single id_* register, 1-cycle latency.
// Holds the word and the PC while decode stalls; a redirect flushes and wins over stalls.
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = DEF_RESET_PC,
    parameter int          MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  pc_plus4;
    logic         past_end;
    logic         advance;
    logic         capture;
    logic         handshake;

    assign past_end  = pc_plus4 > MEM_LIMIT;
    assign handshake = id_valid && id_ready;
    assign advance   = (state == RUN) && !branch_taken && (!id_valid || id_ready);
    // The edge that discovers the end of memory halts instead of fetching.
    assign capture   = advance && !past_end;

    assign Inst_Address = (state == RUN) ? pc : 64'h0;
    assign halted       = (state == HALT);

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .redirect (branch_taken),
        .target   (branch_target),
        .advance  (capture),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= RUN;
            id_valid       <= 1'b0;
            id_pc          <= 64'h0;
            id_instruction <= NOP_INSTR;
            misalign_err   <= 1'b0;
            fetch_count    <= 32'h0;
        end else begin
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (branch_taken) begin
                state    <= RUN;
                id_valid <= 1'b0;
                if (branch_target[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else if ((state == RUN) && past_end) begin
                state <= HALT;
                if (handshake) begin
                    id_valid <= 1'b0;
                end
            end else if (capture) begin
                id_valid       <= 1'b1;
                id_pc          <= pc;
                id_instruction <= Instruction;
            end else if (handshake) begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule
